// File: rtl/seq_mac_multiplier.sv
// rtl/seq_mac_multiplier.sv - sequential shift-add multiply-accumulate unit
// One multiplier bit per clock; result either overwritten or accumulated with a sticky overflow flag.
module seq_mac_multiplier #(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  accum,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  overflow
);

   localparam int PW = 2*DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] a_reg, b_reg;
   logic                  accum_reg;
   logic [PW-1:0]         partial, addend, partial_nx;
   logic [CW-1:0]         cnt;
   logic                  last_iter;
   logic [ACC_WIDTH:0]    prod_ext, acc_sum;

   // Datapath: the final iteration's partial sum feeds the result write on the same edge.
   always_comb begin
      addend     = PW'(a_reg) << cnt;
      partial_nx = b_reg[0] ? (partial + addend) : partial;
      last_iter  = (cnt == CW'(DATA_WIDTH-1));
      prod_ext   = '0;
      prod_ext[PW-1:0] = partial_nx;
      acc_sum    = {1'b0, result} + prod_ext;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (last_iter) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign ready = (state == IDLE);
   assign busy  = (state == CALC);
   assign done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         accum_reg <= 1'b0;
         partial   <= '0;
         cnt       <= '0;
         result    <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg     <= A;
                  b_reg     <= B;
                  accum_reg <= accum;
                  partial   <= '0;
                  cnt       <= '0;
               end
            end
            CALC: begin
               partial <= partial_nx;
               b_reg   <= b_reg >> 1;
               cnt     <= cnt + CW'(1);
               if (last_iter) begin
                  if (accum_reg) begin
                     result   <= acc_sum[ACC_WIDTH-1:0];
                     overflow <= overflow | acc_sum[ACC_WIDTH];
                  end else begin
                     result   <= prod_ext[ACC_WIDTH-1:0];
                     overflow <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// tb/tb_seq_mac_multiplier.sv - self-checking bench for seq_mac_multiplier
// Timestamp-based reference model for the 4-bit unit plus literal checks on 4/8-bit and narrow-accumulator instances.
module tb_seq_mac_multiplier;

   localparam int DW  = 4;
   localparam int AW  = 12;
   localparam int DW8 = 8;
   localparam int AW8 = 20;
   localparam int AWN = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1, start = 1'b0, accum = 1'b0;
   logic [DW-1:0] a = '0, b = '0;
   logic          ready, busy, done, overflow;
   logic [AW-1:0] result;

   logic           start8 = 1'b0;
   logic [DW8-1:0] a8 = '0, b8 = '0;
   logic           ready8, busy8, done8, overflow8;
   logic [AW8-1:0] result8;

   logic           readyn, busyn, donen, overflown;
   logic [AWN-1:0] resultn;

   seq_mac_multiplier #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .accum(accum), .A(a), .B(b),
      .ready(ready), .busy(busy), .done(done), .result(result), .overflow(overflow));

   seq_mac_multiplier #(.DATA_WIDTH(DW8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .accum(1'b0), .A(a8), .B(b8),
      .ready(ready8), .busy(busy8), .done(done8), .result(result8), .overflow(overflow8));

   seq_mac_multiplier #(.DATA_WIDTH(DW), .ACC_WIDTH(AWN)) dutn (
      .clk(clk), .rst_n(rst_n), .start(start), .accum(accum), .A(a), .B(b),
      .ready(readyn), .busy(busyn), .done(donen), .result(resultn), .overflow(overflown));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an operation accepted at edge e completes at edge e+DW and frees the unit at e+DW+2.
   int          edge_no   = 0;
   int          free_edge = 0;
   int          done_edge = -1;
   int          acc_edge  = -100;
   bit          model_on  = 1'b0;
   longint      m_res     = 0;
   bit          m_ovf     = 1'b0;
   longint      pend_res  = 0;
   bit          pend_ovf  = 1'b0;
   bit          exp_ready, exp_busy, exp_done;

   always @(posedge clk) begin
      longint s;
      edge_no++;
      if (!rst_n) begin
         model_on  = 1'b1;
         m_res     = 0;
         m_ovf     = 1'b0;
         free_edge = edge_no + 1;
         done_edge = -1;
         acc_edge  = -100;
      end else if (model_on) begin
         if (done_edge == edge_no) begin
            m_res = pend_res;
            m_ovf = pend_ovf;
         end
         if (start && edge_no >= free_edge) begin
            acc_edge  = edge_no;
            done_edge = edge_no + DW;
            free_edge = edge_no + DW + 2;
            s = longint'(a) * longint'(b);
            if (accum) begin
               s        = s + m_res;
               pend_res = s % (longint'(1) << AW);
               pend_ovf = m_ovf | (s >= (longint'(1) << AW));
            end else begin
               pend_res = s;
               pend_ovf = 1'b0;
            end
         end
      end
      exp_ready = (edge_no + 1 >= free_edge);
      exp_busy  = (edge_no >= acc_edge) && (edge_no <= acc_edge + DW - 1);
      exp_done  = (edge_no == done_edge);
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("ready", 64'(ready), 64'(exp_ready));
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("done", 64'(done), 64'(exp_done));
         chk("result", 64'(result), 64'(m_res));
         chk("overflow", 64'(overflow), 64'(m_ovf));
      end
   end

   int lat;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      start8 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
   endtask

   task automatic op(input int av, input int bv, input bit acc);
      wait_ready();
      a = DW'(av);
      b = DW'(bv);
      accum = acc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic op8(input int av, input int bv);
      a8 = DW8'(av);
      b8 = DW8'(bv);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      if (!done8) chk("done8_timeout", 64'(done8), 64'd1);
   endtask

   initial begin
      int n;
      int dones;
      do_reset();
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_result", 64'(result), 64'd0);

      // 13*11
      op(13, 11, 1'b0);
      chk("t1_latency", 64'(lat), 64'd4);
      chk("t1_result", 64'(result), 64'd143);
      chk("t1_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      chk("t1_ready_after", 64'(ready), 64'd1);

      // 225 then 450; narrow accumulator wraps 450 to 194
      do_reset();
      op(15, 15, 1'b0);
      chk("t2_first", 64'(result), 64'd225);
      op(15, 15, 1'b1);
      chk("t2_second", 64'(result), 64'd450);
      chk("t2_ovf", 64'(overflow), 64'd0);
      chk("tn_wrap", 64'(resultn), 64'd194);
      chk("tn_ovf", 64'(overflown), 64'd1);

      // accumulator saturation into overflow
      do_reset();
      for (int i = 0; i < 18; i++) op(15, 15, 1'b1);
      chk("t3_18th", 64'(result), 64'd4050);
      chk("t3_18th_ovf", 64'(overflow), 64'd0);
      op(15, 15, 1'b1);
      chk("t3_19th", 64'(result), 64'd179);
      chk("t3_19th_ovf", 64'(overflow), 64'd1);
      op(15, 15, 1'b1);
      chk("t3_sticky_ovf", 64'(overflow), 64'd1);
      op(2, 3, 1'b0);
      chk("t3_clear", 64'(result), 64'd6);
      chk("t3_clear_ovf", 64'(overflow), 64'd0);

      // start during CALC is dropped
      wait_ready();
      a = 4'd9; b = 4'd7; accum = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd1; b = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_result", 64'(result), 64'd63);
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("t4_single_done", 64'(dones), 64'd0);

      // start held high: done every DW+2 cycles
      a = 4'd2; b = 4'd3; start = 1'b1;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_period", 64'(n), 64'd6);
      start = 1'b0;

      // reset mid-operation
      wait_ready();
      a = 4'd13; b = 4'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t5_ready", 64'(ready), 64'd1);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_result", 64'(result), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      op(3, 5, 1'b0);
      chk("t5_after", 64'(result), 64'd15);

      // 8-bit instance
      op8(255, 255);
      chk("t6_latency_ff", 64'(lat), 64'd8);
      chk("t6_result_ff", 64'(result8), 64'd65025);
      chk("t6_ovf", 64'(overflow8), 64'd0);
      @(negedge clk);
      @(negedge clk);
      op8(0, 200);
      chk("t6_latency_zero", 64'(lat), 64'd8);
      chk("t6_result_zero", 64'(result8), 64'd0);

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 99) != 0);
         start = ($urandom_range(0, 2) == 0);
         accum = ($urandom_range(0, 3) != 0);
         a = DW'($urandom);
         b = DW'($urandom);
      end
      start = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
